// File: rtl/pipe_stage_buf.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_stage_buf
//  Purpose  : One pipeline stage boundary carrying a control field and a data
//             field between two stages, with a valid/ready handshake, an
//             optional 1-entry skid register, synchronous flush (bubble
//             insertion) and a saturating back-pressure counter.
//  Ports    : CLK        rising-edge clock
//             Reset      synchronous active-high reset
//             Flush      synchronous discard of all held entries
//             in_valid   upstream entry present
//             in_ready   stage accepts in_* this cycle
//             in_ctrl    upstream control field  [CTRL_W]
//             in_data    upstream data field     [DATA_W]
//             out_valid  out_* holds a valid entry
//             out_ready  downstream consumes this cycle
//             out_ctrl   control field, zero while out_valid=0
//             out_data   data field, holds its last value when empty
//             stall_cnt  saturating count of in_valid && !in_ready edges
//  Revision : 1.0  initial release
// ============================================================================
module pipe_stage_buf #(
    parameter int CTRL_W  = 6,
    parameter int DATA_W  = 51,
    parameter int SKID_EN = 1,
    parameter int CNT_W   = 16
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              Flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [1:0] c_ST_EMPTY = 2'd0;
    localparam logic [1:0] c_ST_FULL  = 2'd1;
    localparam logic [1:0] c_ST_SKID  = 2'd2;

    localparam bit               c_SKID_MODE = (SKID_EN != 0);
    localparam logic [CNT_W-1:0] c_CNT_MAX   = '1;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              w_ld_main_in;
    logic              w_ld_main_skid;
    logic              w_ld_skid;

    logic [CTRL_W-1:0] r_main_ctrl;
    logic [DATA_W-1:0] r_main_data;
    logic [CTRL_W-1:0] w_skid_ctrl;
    logic [DATA_W-1:0] w_skid_data;
    logic [CNT_W-1:0]  r_stall_cnt;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state <= c_ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and load-enable decode. Flush wins over every handshake:
    // no register is loaded, so an entry offered in the flush cycle is
    // dropped and the data registers keep their contents.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_ld_main_in   = 1'b0;
        w_ld_main_skid = 1'b0;
        w_ld_skid      = 1'b0;
        if (Flush) begin
            w_state_nxt = c_ST_EMPTY;
        end else begin
            case (r_state)
                c_ST_EMPTY: begin
                    if (in_valid) begin
                        w_ld_main_in = 1'b1;
                        w_state_nxt  = c_ST_FULL;
                    end
                end
                c_ST_FULL: begin
                    if (out_ready) begin
                        if (in_valid) begin
                            w_ld_main_in = 1'b1;
                        end else begin
                            w_state_nxt = c_ST_EMPTY;
                        end
                    end else if (in_valid && c_SKID_MODE) begin
                        // in_ready was high (registered), so the entry must
                        // be parked rather than refused.
                        w_ld_skid   = 1'b1;
                        w_state_nxt = c_ST_SKID;
                    end
                end
                c_ST_SKID: begin
                    if (out_ready) begin
                        w_ld_main_skid = 1'b1;
                        w_state_nxt    = c_ST_FULL;
                    end
                end
                default: begin
                    w_state_nxt = c_ST_EMPTY;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output decode. With the skid register, in_ready is a pure state
    // decode so there is no out_ready -> in_ready combinational path.
    // ------------------------------------------------------------------
    always_comb begin
        out_valid = (r_state != c_ST_EMPTY);
        out_ctrl  = (r_state != c_ST_EMPTY) ? r_main_ctrl : '0;
        out_data  = r_main_data;
        if (c_SKID_MODE) begin
            in_ready = (r_state != c_ST_SKID);
        end else begin
            in_ready = (r_state == c_ST_EMPTY) || out_ready;
        end
    end

    // ------------------------------------------------------------------
    // Main register (drives out_*)
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_main_ctrl <= '0;
            r_main_data <= '0;
        end else if (w_ld_main_in) begin
            r_main_ctrl <= in_ctrl;
            r_main_data <= in_data;
        end else if (w_ld_main_skid) begin
            r_main_ctrl <= w_skid_ctrl;
            r_main_data <= w_skid_data;
        end
    end

    // ------------------------------------------------------------------
    // Skid register, present only in skid mode
    // ------------------------------------------------------------------
    generate
        if (SKID_EN != 0) begin : g_skid
            logic [CTRL_W-1:0] r_skid_ctrl;
            logic [DATA_W-1:0] r_skid_data;

            always_ff @(posedge CLK) begin
                if (Reset) begin
                    r_skid_ctrl <= '0;
                    r_skid_data <= '0;
                end else if (w_ld_skid) begin
                    r_skid_ctrl <= in_ctrl;
                    r_skid_data <= in_data;
                end
            end

            assign w_skid_ctrl = r_skid_ctrl;
            assign w_skid_data = r_skid_data;
        end else begin : g_no_skid
            assign w_skid_ctrl = '0;
            assign w_skid_data = '0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Back-pressure counter: saturating, cleared only by Reset
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_stall_cnt <= '0;
        end else if (in_valid && !in_ready && (r_stall_cnt != c_CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_buf.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_stage_buf
//  Purpose  : Self-checking bench for pipe_stage_buf. Three instances share
//             one stimulus stream: skid mode (16-bit counter), single-entry
//             mode, and skid mode with a 4-bit counter. Each instance has a
//             queue-based reference model; outputs are compared every cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipe_stage_buf;

    logic        CLK;
    logic        Reset;
    logic        Flush;
    logic        in_valid;
    logic        out_ready;
    logic [5:0]  in_ctrl;
    logic [50:0] in_data;

    logic        ir0, ov0, ir1, ov1, ir2, ov2;
    logic [5:0]  oc0, oc1, oc2;
    logic [50:0] od0, od1, od2;
    logic [15:0] sc0, sc1;
    logic [3:0]  sc2;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    pipe_stage_buf #(.CTRL_W(6), .DATA_W(51), .SKID_EN(1), .CNT_W(16)) u_skid (
        .CLK(CLK), .Reset(Reset), .Flush(Flush),
        .in_valid(in_valid), .in_ready(ir0), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(ov0), .out_ready(out_ready), .out_ctrl(oc0), .out_data(od0),
        .stall_cnt(sc0)
    );

    pipe_stage_buf #(.CTRL_W(6), .DATA_W(51), .SKID_EN(0), .CNT_W(16)) u_noskid (
        .CLK(CLK), .Reset(Reset), .Flush(Flush),
        .in_valid(in_valid), .in_ready(ir1), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(ov1), .out_ready(out_ready), .out_ctrl(oc1), .out_data(od1),
        .stall_cnt(sc1)
    );

    pipe_stage_buf #(.CTRL_W(6), .DATA_W(51), .SKID_EN(1), .CNT_W(4)) u_sat (
        .CLK(CLK), .Reset(Reset), .Flush(Flush),
        .in_valid(in_valid), .in_ready(ir2), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(ov2), .out_ready(out_ready), .out_ctrl(oc2), .out_data(od2),
        .stall_cnt(sc2)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // ------------------------------------------------------------------
    // Reference model: a bounded FIFO per instance
    // ------------------------------------------------------------------
    int unsigned c_max [3] = '{32'd65535, 32'd65535, 32'd15};
    bit          c_sk  [3] = '{1'b1, 1'b0, 1'b1};
    logic [56:0] m_q   [3][2];
    int          m_n   [3];
    logic [50:0] m_last[3];
    int unsigned m_sc  [3];

    function automatic bit exp_ir(int i);
        if (c_sk[i]) return (m_n[i] < 2);
        return (m_n[i] == 0) || out_ready;
    endfunction

    task automatic model_step();
        for (int i = 0; i < 3; i++) begin
            automatic bit ir   = exp_ir(i);
            automatic bit pop  = (m_n[i] > 0) && out_ready;
            automatic bit push = in_valid && ir;
            if (Reset) begin
                m_n[i]    = 0;
                m_last[i] = '0;
                m_sc[i]   = 0;
            end else begin
                if (in_valid && !ir && (m_sc[i] < c_max[i])) m_sc[i] = m_sc[i] + 1;
                if (Flush) begin
                    m_n[i] = 0;
                end else begin
                    if (pop) begin
                        m_q[i][0] = m_q[i][1];
                        m_n[i]    = m_n[i] - 1;
                    end
                    if (push) begin
                        m_q[i][m_n[i]] = {in_ctrl, in_data};
                        m_n[i]         = m_n[i] + 1;
                    end
                end
                if (m_n[i] > 0) m_last[i] = m_q[i][0][50:0];
            end
        end
    endtask

    task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic act_ov(int i);
        case (i) 0: return ov0; 1: return ov1; default: return ov2; endcase
    endfunction
    function automatic logic act_ir(int i);
        case (i) 0: return ir0; 1: return ir1; default: return ir2; endcase
    endfunction
    function automatic logic [5:0] act_oc(int i);
        case (i) 0: return oc0; 1: return oc1; default: return oc2; endcase
    endfunction
    function automatic logic [50:0] act_od(int i);
        case (i) 0: return od0; 1: return od1; default: return od2; endcase
    endfunction
    function automatic logic [15:0] act_sc(int i);
        case (i) 0: return sc0; 1: return sc1; default: return {12'd0, sc2}; endcase
    endfunction

    task automatic compare_all();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("inst%0d out_valid", i), 64'(act_ov(i)), 64'(m_n[i] > 0));
            check($sformatf("inst%0d out_ctrl", i), 64'(act_oc(i)),
                  (m_n[i] > 0) ? 64'(m_q[i][0][56:51]) : 64'd0);
            check($sformatf("inst%0d out_data", i), 64'(act_od(i)), 64'(m_last[i]));
            check($sformatf("inst%0d in_ready", i), 64'(act_ir(i)), 64'(exp_ir(i)));
            check($sformatf("inst%0d stall_cnt", i), 64'(act_sc(i)), 64'(m_sc[i]));
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            m_n[i] = 0; m_last[i] = '0; m_sc[i] = 0;
            m_q[i][0] = '0; m_q[i][1] = '0;
        end
        forever begin
            @(posedge CLK);
            model_step();
        end
    end

    initial begin
        forever begin
            @(negedge CLK);
            if (chk_en) compare_all();
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1; Flush = 1'b0; in_valid = 1'b0;
        step();
        Reset = 1'b0;
    endtask

    initial begin
        Reset = 1'b0; Flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_ctrl = '0; in_data = '0;
        step();

        // Reset with garbage inputs and competing Flush/handshake
        Reset = 1'b1; Flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        in_ctrl = 6'h3F; in_data = '1;
        step();
        Reset = 1'b0; Flush = 1'b0; in_valid = 1'b0; chk_en = 1'b1;
        #1;
        check("rst out_valid", 64'(ov0), 64'd0);
        check("rst out_ctrl", 64'(oc0), 64'd0);
        check("rst out_data", 64'(od0), 64'd0);
        check("rst in_ready", 64'(ir0), 64'd1);
        check("rst stall_cnt", 64'(sc0), 64'd0);

        // Streaming at full rate
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; in_ctrl = 6'(k + 1); in_data = 51'(32'h100 + k);
            #1;
            check($sformatf("stream in_ready %0d", k), 64'(ir0), 64'd1);
            step();
            check($sformatf("stream out_data %0d", k), 64'(od0), 64'(32'h100 + k));
            check($sformatf("stream out_valid %0d", k), 64'(ov0), 64'd1);
            check($sformatf("stream out_ctrl %0d", k), 64'(oc0), 64'(k + 1));
        end
        in_valid = 1'b0;
        step();
        check("stream model last", 64'(m_last[0]), 64'h104);
        check("stream drained", 64'(ov0), 64'd0);

        // Back-pressure into the skid register
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 6'h01;
        in_data = 51'h11; step();
        in_data = 51'h22; step();
        in_data = 51'h33; repeat (3) step();
        check("bp in_ready", 64'(ir0), 64'd0);
        check("bp stall_cnt", 64'(sc0), 64'd3);
        check("bp head A", 64'(od0), 64'h11);
        out_ready = 1'b1;
        step();
        check("bp second B", 64'(od0), 64'h22);
        step();
        check("bp third C", 64'(od0), 64'h33);
        in_valid = 1'b0;
        step();
        check("bp drained", 64'(ov0), 64'd0);

        // Flush with the skid register occupied and an entry offered
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 6'h2A;
        in_data = 51'h11; step();
        in_data = 51'h22; step();
        in_data = 51'h33; step();
        Flush = 1'b1; step();
        Flush = 1'b0; in_valid = 1'b0;
        #1;
        check("flush out_valid", 64'(ov0), 64'd0);
        check("flush out_ctrl", 64'(oc0), 64'd0);
        check("flush in_ready", 64'(ir0), 64'd1);
        check("flush stall_cnt kept", 64'(sc0), 64'd2);
        check("flush data held", 64'(od0), 64'h11);
        out_ready = 1'b1;
        repeat (3) step();
        check("flush nothing resurfaces", 64'(ov0), 64'd0);

        // Single-entry mode: combinational in_ready
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 6'h05;
        in_data = 51'h44; step();
        in_data = 51'h55;
        #1;
        check("noskid in_ready blocked", 64'(ir1), 64'd0);
        out_ready = 1'b1;
        #1;
        check("noskid in_ready comb", 64'(ir1), 64'd1);
        step();
        check("noskid replaced", 64'(od1), 64'h55);
        check("noskid out_valid", 64'(ov1), 64'd1);
        in_valid = 1'b0;
        step();

        // Counter saturation
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1;
        repeat (22) step();
        check("sat 4-bit", 64'(sc2), 64'hF);
        check("sat 16-bit", 64'(sc0), 64'd20);
        Reset = 1'b1;
        step();
        Reset = 1'b0; in_valid = 1'b0;
        check("sat cleared", 64'(sc2), 64'd0);

        // Randomised traffic in phases of varying back-pressure
        for (int ph = 0; ph < 6; ph++) begin
            for (int c = 0; c < 500; c++) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                out_ready = ($urandom_range(0, 5) < ph);
                Flush     = ($urandom_range(0, 24) == 0);
                Reset     = ($urandom_range(0, 299) == 0);
                in_ctrl   = 6'($urandom);
                in_data   = 51'({$urandom, $urandom});
                step();
            end
        end
        Reset = 1'b0; Flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) step();

        @(negedge CLK);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
